// File: rtl/lpc_ring_ctrl_if.sv
// Port bundle between lpc_ring_ctrl and its dual-port ring buffer (registered read).
interface lpc_ring_ctrl_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          write_clock_enable;
  logic [AW-1:0] write_addr;
  logic [DW-1:0] write_data;
  logic          read_clock_enable;
  logic [AW-1:0] read_addr;
  logic [DW-1:0] read_data;

  modport master (
    output write_clock_enable, write_addr, write_data,
    output read_clock_enable, read_addr,
    input  read_data
  );

  modport slave (
    input  write_clock_enable, write_addr, write_data,
    input  read_clock_enable, read_addr,
    output read_data
  );
endinterface

// File: rtl/lpc_ring_ctrl.sv
// FIFO sequencer for one dual-port ring buffer: LPC capture in, UART valid/ready out.
// Optional saturating drop counter enabled by defining LPC_RING_DROP_COUNT_EN.
//
// state | meaning
// IDLE  | nothing in flight; issue a read as soon as an entry is stored
// FETCH | read issued last edge; buffer read register loads at this edge
// HOLD  | out_data valid and held until the consumer takes it
module lpc_ring_ctrl #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  input  logic          flush,
  input  logic          clear_overflow,
  output logic [AW:0]   level,
  output logic          empty,
  output logic          full,
  output logic          overflow,
`ifdef LPC_RING_DROP_COUNT_EN
  output logic [15:0]   drop_count,
`endif
  lpc_ring_ctrl_if.master buf_if
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  localparam logic [AW:0] CAP = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

  state_t      state_q, state_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        out_valid_q, out_valid_d;
  logic        overflow_q, overflow_d;
  logic        wr_en, rd_en, drop;
`ifdef LPC_RING_DROP_COUNT_EN
  logic [15:0] drop_count_q, drop_count_d;
`endif

  assign level = wr_ptr_q - rd_ptr_q;
  assign empty = (level == '0);
  assign full  = (level == CAP);

  always_comb begin
    // Enables are forced low while reset is held so the buffer sees no stray write.
    wr_en       = in_valid & ~full & ~flush & reset_n;
    drop        = in_valid & full & ~flush;
    rd_en       = 1'b0;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    state_d     = state_q;
    out_valid_d = out_valid_q;

    if (wr_en) wr_ptr_d = wr_ptr_q + ONE;

    if (flush) begin
      rd_ptr_d    = wr_ptr_q;
      state_d     = IDLE;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!empty) begin
            rd_en    = 1'b1;
            rd_ptr_d = rd_ptr_q + ONE;
            state_d  = FETCH;
          end
        end
        FETCH: begin
          state_d     = HOLD;
          out_valid_d = 1'b1;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            if (!empty) begin
              rd_en    = 1'b1;
              rd_ptr_d = rd_ptr_q + ONE;
              state_d  = FETCH;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      endcase
    end

    // A drop in the same cycle as clear_overflow keeps the flag set.
    overflow_d = drop | (overflow_q & ~clear_overflow);

`ifdef LPC_RING_DROP_COUNT_EN
    if (clear_overflow)
      drop_count_d = {15'd0, drop};
    else if (drop && drop_count_q != 16'hFFFF)
      drop_count_d = drop_count_q + 16'd1;
    else
      drop_count_d = drop_count_q;
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      out_valid_q  <= 1'b0;
      overflow_q   <= 1'b0;
`ifdef LPC_RING_DROP_COUNT_EN
      drop_count_q <= 16'd0;
`endif
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      out_valid_q  <= out_valid_d;
      overflow_q   <= overflow_d;
`ifdef LPC_RING_DROP_COUNT_EN
      drop_count_q <= drop_count_d;
`endif
    end
  end

  assign out_valid                 = out_valid_q;
  assign overflow                  = overflow_q;
  assign out_data                  = buf_if.read_data;
  assign buf_if.write_clock_enable = wr_en;
  assign buf_if.write_addr         = wr_ptr_q[AW-1:0];
  assign buf_if.write_data         = in_data;
  assign buf_if.read_clock_enable  = rd_en;
  assign buf_if.read_addr          = rd_ptr_q[AW-1:0];
`ifdef LPC_RING_DROP_COUNT_EN
  assign drop_count                = drop_count_q;
`endif

endmodule
